// File: rtl/eth_mac_pkg.sv
// Shared definitions for the Ethernet TX frame arbiter: arbiter state
// encoding, grant index width and the frame length counter width helper.
package eth_mac_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_XFER  = 2'd1,
        ST_DRAIN = 2'd2
    } arb_state_t;

    localparam int GRANT_IDX_W = 3;

    function automatic int len_cnt_width(input int max_len);
        return $clog2(max_len + 1);
    endfunction

endpackage

// File: rtl/rr_priority_select.sv
// Round-robin requester search: first active request at or after ptr,
// wrapping modulo PORTS.
module rr_priority_select
    import eth_mac_pkg::*;
#(
    parameter int PORTS = 4
) (
    input  logic [PORTS-1:0]       req,
    input  logic [GRANT_IDX_W-1:0] ptr,
    output logic [PORTS-1:0]       grant,
    output logic [GRANT_IDX_W-1:0] index,
    output logic                   valid
);

    localparam int IW = (PORTS > 1) ? $clog2(PORTS) : 1;

    logic [IW-1:0] cand;

    always_comb begin
        grant = '0;
        index = '0;
        valid = 1'b0;
        cand  = '0;
        for (int i = 0; i < PORTS; i++) begin
            cand = IW'((int'(ptr) + i) % PORTS);
            if (!valid && req[cand]) begin
                valid       = 1'b1;
                index       = GRANT_IDX_W'(cand);
                grant[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/eth_tx_frame_arbiter.sv
// Frame-granular round-robin arbiter merging AXI-stream requesters into the
// MAC TX FIFO, truncating frames that exceed MAX_FRAME_LEN beats.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | no frame owned; arbitrate among enabled, valid requesters
//   ST_XFER  | granted port's beats pass straight through to m_axis
//   ST_DRAIN | frame truncated; swallow granted port's beats until tlast
module eth_tx_frame_arbiter
    import eth_mac_pkg::*;
#(
    parameter int PORTS         = 4,
    parameter int DATA_WIDTH    = 8,
    parameter int MAX_FRAME_LEN = 1522
) (
    input  logic                        logic_clk,
    input  logic                        logic_rst_n,
    input  logic [PORTS*DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [PORTS-1:0]            s_axis_tvalid,
    output logic [PORTS-1:0]            s_axis_tready,
    input  logic [PORTS-1:0]            s_axis_tlast,
    input  logic [PORTS-1:0]            s_axis_tuser,
    output logic [DATA_WIDTH-1:0]       m_axis_tdata,
    output logic                        m_axis_tvalid,
    input  logic                        m_axis_tready,
    output logic                        m_axis_tlast,
    output logic                        m_axis_tuser,
    input  logic [PORTS-1:0]            cfg_port_enable,
    output logic                        grant_valid,
    output logic [2:0]                  grant_index,
    output logic                        stat_truncated,
    output logic                        stat_frame_done
);

    localparam int IW = (PORTS > 1) ? $clog2(PORTS) : 1;
    localparam int CW = len_cnt_width(MAX_FRAME_LEN);
    localparam logic [CW-1:0] LAST_CNT = CW'(MAX_FRAME_LEN - 1);

    arb_state_t             state;
    logic [GRANT_IDX_W-1:0] grant_idx;
    logic [GRANT_IDX_W-1:0] rr_ptr;
    logic [GRANT_IDX_W-1:0] sel_idx;
    logic [PORTS-1:0]       grant_oh;
    logic [PORTS-1:0]       sel_oh;
    logic [PORTS-1:0]       req;
    logic                   sel_valid;
    logic [CW-1:0]          beat_cnt;
    logic [IW-1:0]          gsel;
    logic                   g_valid;
    logic                   g_last;
    logic                   g_user;
    logic                   g_beat;
    logic                   trunc_beat;

    assign req = s_axis_tvalid & cfg_port_enable;

    rr_priority_select #(.PORTS(PORTS)) u_rr_select (
        .req   (req),
        .ptr   (rr_ptr),
        .grant (sel_oh),
        .index (sel_idx),
        .valid (sel_valid)
    );

    assign gsel       = grant_idx[IW-1:0];
    assign g_valid    = s_axis_tvalid[gsel];
    assign g_last     = s_axis_tlast[gsel];
    assign g_user     = s_axis_tuser[gsel];
    // Beat that reaches the length limit without the source's own tlast
    assign trunc_beat = (beat_cnt == LAST_CNT) && !g_last;
    assign g_beat     = (state == ST_XFER) && g_valid && m_axis_tready;

    assign grant_valid = (state != ST_IDLE);
    assign grant_index = grant_idx;

    always_comb begin
        m_axis_tdata  = '0;
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        m_axis_tuser  = 1'b0;
        s_axis_tready = '0;
        case (state)
            ST_XFER: begin
                m_axis_tdata  = s_axis_tdata[gsel*DATA_WIDTH +: DATA_WIDTH];
                m_axis_tvalid = g_valid;
                m_axis_tlast  = g_last | trunc_beat;
                m_axis_tuser  = g_user | trunc_beat;
                s_axis_tready = grant_oh & {PORTS{m_axis_tready}};
            end
            ST_DRAIN: s_axis_tready = grant_oh;
            default: ;
        endcase
    end

    always_ff @(posedge logic_clk) begin
        if (!logic_rst_n) begin
            state           <= ST_IDLE;
            grant_idx       <= '0;
            grant_oh        <= '0;
            rr_ptr          <= '0;
            beat_cnt        <= '0;
            stat_truncated  <= 1'b0;
            stat_frame_done <= 1'b0;
        end else begin
            stat_truncated  <= 1'b0;
            stat_frame_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (sel_valid) begin
                        grant_idx <= sel_idx;
                        grant_oh  <= sel_oh;
                        rr_ptr    <= GRANT_IDX_W'((int'(sel_idx) + 1) % PORTS);
                        beat_cnt  <= '0;
                        state     <= ST_XFER;
                    end
                end
                ST_XFER: begin
                    if (g_beat) begin
                        beat_cnt <= beat_cnt + 1'b1;
                        if (g_last) begin
                            stat_frame_done <= 1'b1;
                            state           <= ST_IDLE;
                        end else if (trunc_beat) begin
                            stat_frame_done <= 1'b1;
                            stat_truncated  <= 1'b1;
                            state           <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (g_valid && g_last) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/eth_tx_frame_arbiter.md
ETH_TX_FRAME_ARBITER -- requirements
Module: eth_tx_frame_arbiter

Interface
REQ-001 SHALL have parameter PORTS, default 4, number of AXI-stream requesters (2..8).
REQ-002 SHALL have parameter DATA_WIDTH, default 8, tdata width per port.
REQ-003 SHALL have parameter MAX_FRAME_LEN, default 1522, byte limit before forced truncation.
REQ-004 SHALL have ports:
- logic_clk  in  1  sole clock
- logic_rst_n  in  1  synchronous active-low reset
- s_axis_tdata  in  PORTS*DATA_WIDTH  per-port data
- s_axis_tvalid / s_axis_tready  in / out  PORTS  per-port handshake
- s_axis_tlast, s_axis_tuser  in  PORTS  per-port end-of-frame, bad-frame
- m_axis_tdata  out  DATA_WIDTH  to MAC TX FIFO input
- m_axis_tvalid / m_axis_tready  out / in  1  output handshake
- m_axis_tlast, m_axis_tuser  out  1  output end-of-frame, bad-frame
- cfg_port_enable  in  PORTS  per-port arbitration enable
- grant_valid  out  1  frame in progress
- grant_index  out  3  current port
- stat_truncated  out  1  one-cycle pulse per truncated frame
- stat_frame_done  out  1  one-cycle pulse per forwarded frame

Function
REQ-005 SHALL arbitrate at frame granularity: once granted, a port keeps the output until its frame ends (tlast accepted or truncation complete).
REQ-006 SHALL use round-robin priority: search starts at (last granted index + 1) mod PORTS; after reset search starts at port 0.
REQ-007 SHALL consider a port requesting only when s_axis_tvalid=1 and cfg_port_enable=1.
REQ-008 SHALL implement states IDLE, XFER, DRAIN; IDLE->XFER when any port requests, grant registered, first beat forwardable the cycle after grant.
REQ-009 In XFER, SHALL pass granted port's tdata/tvalid/tlast/tuser to m_axis combinationally and m_axis_tready to that port's tready only; all other tready SHALL be 0.
REQ-010 SHALL return XFER->IDLE on accepted beat with tlast=1, pulsing stat_frame_done; IDLE SHALL arbitrate the same cycle it is entered (one idle cycle between frames).
REQ-011 SHALL count accepted beats in XFER with a counter of clog2(MAX_FRAME_LEN+1) bits, cleared on grant.
REQ-012 When the beat that makes count equal MAX_FRAME_LEN is accepted without tlast, SHALL drive m_axis_tlast=1 and m_axis_tuser=1 on that beat, pulse stat_truncated and stat_frame_done, and enter DRAIN.
REQ-013 In DRAIN, SHALL hold m_axis_tvalid=0, assert granted port's tready=1, discard beats, and return to IDLE after the port's tlast is accepted.
REQ-014 Frame of exactly MAX_FRAME_LEN beats ending with tlast SHALL pass unmodified, no truncation.
REQ-015 Deasserting cfg_port_enable mid-frame SHALL NOT abort the frame in progress; it affects only subsequent arbitration.
REQ-016 s_axis_tuser SHALL be forwarded unchanged except as REQ-012 forces it.
REQ-017 grant_valid SHALL be 1 in XFER and DRAIN; grant_index SHALL hold last grant when idle.
REQ-018 In IDLE, m_axis_tvalid and all s_axis_tready SHALL be 0.

Reset
REQ-019 On logic_rst_n=0 sampled at logic_clk rising edge: state IDLE, counter 0, round-robin pointer to port 0, grant_index 0, grant_valid 0, stat pulses 0, m_axis_tvalid 0, all tready 0.
REQ-020 Reset mid-frame SHALL abandon the frame without emitting tlast; the downstream FIFO's bad-frame handling is responsible.

Structure
REQ-021 State encoding constants and length-counter width function SHALL live in shared package eth_mac_pkg.
REQ-022 Round-robin selection SHALL be a sub-module rr_priority_select (request vector, pointer in; one-hot grant, index, valid out).

Verification
REQ-023 Ports 0,2 both request at reset release, 64-beat frames -> port 0 frame fully forwarded, then port 2, grant_index 0 then 2, two stat_frame_done pulses.
REQ-024 All 4 ports continuously requesting, 10-beat frames -> grant order 0,1,2,3,0; no beat interleaving between frames.
REQ-025 Port 1 sends 1600-beat frame, MAX_FRAME_LEN=1522 -> 1522 output beats, beat 1522 tlast=1 tuser=1, stat_truncated once, remaining 78 input beats consumed with m_axis_tvalid=0.
REQ-026 Frame exactly 1522 beats with tlast -> forwarded intact, tuser per input, no stat_truncated.
REQ-027 m_axis_tready toggled 50% random during frame -> output sequence byte-identical to input, granted tready mirrors m_axis_tready.
REQ-028 cfg_port_enable=4'b1110 with port 0 requesting -> no grant; logic_rst_n low mid-frame -> all outputs at reset values next cycle.
